mio_bus_ctrl: RTL
=================

Name: mio_bus_ctrl

Overview:
- Parametrised, handshaked successor to the combinational memory/IO bus decoder.
- Sits between the CPU data port and N memory-mapped slaves (data RAM, GPIO banks, counter unit).
- Decodes each CPU access against a per-slot base/mask table and drives a one-hot select, latched address and write data, and a write strobe.
- Waits for the selected slave's ack, returns registered read data with a cycle-accurate ready pulse, and flags unmapped or timed-out accesses as bus errors.

Parameters:
- N_SLV, 4: number of slave slots (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SLV_BASE, {32'hF0000004,32'hF0000000,32'hE0000000,32'h00000000}: packed N_SLV*ADDR_W bases; slot 0 is in the LSBs.
- SLV_MASK, {32'hF0000004,32'hF0000004,32'hF0000000,32'hF0000000}: packed N_SLV*ADDR_W compare masks.
- TIMEOUT, 15: cycles to wait for an ack; 0 = wait forever.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; held by the CPU until cpu_ready.
- mem_w  in  1  1 = write, 0 = read; sampled with cpu_req.
- addr_bus  in  ADDR_W  CPU byte address.
- Cpu_data2bus  in  DATA_W  CPU write data.
- Cpu_data4bus  out  DATA_W  registered read data to the CPU.
- cpu_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  valid with cpu_ready; access unmapped or timed out.
- slv_sel  out  N_SLV  one-hot slave select.
- slv_we  out  1  write strobe, qualified by slv_sel.
- slv_addr  out  ADDR_W  latched address.
- slv_wdata  out  DATA_W  latched write data.
- slv_rdata  in  N_SLV*DATA_W  packed slave read data; slot 0 in the LSBs.
- slv_ack  in  N_SLV  per-slave completion.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, timeout counter = 0. A reset mid-access abandons it: no cpu_ready pulse, slv_sel drops on the next edge.
- Decode: slot i hits when (addr_bus & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]). On multiple hits the lowest index wins.
- IDLE, cpu_req=1 and a slot hits: latch addr/wdata/mem_w and the slot index; drive slv_sel one-hot and slv_we = mem_w; go to ACCESS.
- IDLE, cpu_req=1 and no slot hits: go to RESP with err=1 and rdata=0. slv_sel stays 0.
- ACCESS:
  - slv_sel, slv_we, slv_addr and slv_wdata are held stable.
  - When slv_ack[sel]=1: capture slv_rdata[sel] for a read (0 for a write), deassert sel/we, go to RESP with err=0.
  - Acks from non-selected slots are ignored.
  - The counter increments each cycle without ack. When it reaches TIMEOUT (TIMEOUT != 0): deassert sel, set err=1 and rdata=0, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: cpu_ready=1 for exactly one cycle, with Cpu_data4bus and bus_err valid; go to IDLE. Cpu_data4bus holds its value until the next RESP.
- Latency:
  - Mapped access with a same-cycle ack: cpu_req at edge 0, slv_sel from edge 1, cpu_ready at edge 2.
  - Unmapped access: cpu_ready at edge 1.
- cpu_req in ACCESS/RESP is ignored. The first IDLE cycle after RESP may start a new access, so back-to-back accesses take 3 cycles each.
- Timeout counter width is $clog2(TIMEOUT+1), minimum 1. It clears on entry to ACCESS.

Optional Feature:
- Macro MIO_BUS_ERR_LOG_EN.
- When defined, adds ports err_clr (in, 1), err_valid (out, 1) and err_addr (out, ADDR_W).
  - The first bus error latches its address and sets err_valid. Later errors are not logged while err_valid=1.
  - err_clr clears err_valid and err_addr next cycle. If an error coincides with err_clr, the new error is logged.
  - Both outputs reset to 0.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package mio_bus_pkg: FSM state enum (IDLE, ACCESS, RESP), default base/mask constants, and a clog2-based counter width function.
- One sub-module, mio_addr_dec: purely combinational base/mask compare with priority encoding, giving hit, idx and onehot outputs.

Test Plan:
- Read 0x00000010, slot 0 acks in the first ACCESS cycle with rdata 0x12345678 -> cpu_ready at edge 2, Cpu_data4bus=0x12345678, bus_err=0, slv_sel=4'b0001.
- Write 0xF0000004 with data 0xA5A5A5A5, ack after 3 cycles -> slv_sel=4'b1000, slv_we=1 held for 4 cycles, slv_wdata stable, Cpu_data4bus=0.
- Read 0x40000000 (unmapped) -> cpu_ready at edge 1, bus_err=1, slv_sel never asserted; with the macro: err_addr=0x40000000, err_valid=1.
- Read 0xE0000000, slot 1 never acks, TIMEOUT=15 -> cpu_ready 17 edges after cpu_req, bus_err=1, Cpu_data4bus=0.
- Ack on slot 2 during a slot-1 access, then rst asserted in ACCESS -> the stray ack is ignored; after reset all outputs are 0, no cpu_ready, and the next access proceeds normally.
- Back-to-back reads 0xF0000000 then 0x00000000, each acked immediately -> cpu_ready pulses 3 cycles apart with the correct data each time.

Source files
------------

// File: rtl/mio_bus_pkg.sv
// mio_bus_pkg: shared FSM states, default slot table and width helpers for the bus controller
package mio_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [127:0] DEF_BASE = {32'hF0000004, 32'hF0000000, 32'hE0000000, 32'h00000000};
  localparam logic [127:0] DEF_MASK = {32'hF0000004, 32'hF0000004, 32'hF0000000, 32'hF0000000};
  function automatic int cnt_width(input int t);
    return t > 0 ? $clog2(t + 1) : 1;
  endfunction
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mio_bus_ctrl_if.sv
// mio_bus_ctrl_if: CPU data port plus slave-side select/data/ack bundle
interface mio_bus_ctrl_if #(
  parameter int N_SLV  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                      cpu_req;
  logic                      mem_w;
  logic [ADDR_W-1:0]         addr_bus;
  logic [DATA_W-1:0]         Cpu_data2bus;
  logic [DATA_W-1:0]         Cpu_data4bus;
  logic                      cpu_ready;
  logic                      bus_err;
  logic [N_SLV-1:0]          slv_sel;
  logic                      slv_we;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [N_SLV*DATA_W-1:0]   slv_rdata;
  logic [N_SLV-1:0]          slv_ack;
  modport master (
    output cpu_req, mem_w, addr_bus, Cpu_data2bus, slv_rdata, slv_ack,
    input  Cpu_data4bus, cpu_ready, bus_err, slv_sel, slv_we, slv_addr, slv_wdata
  );
  modport slave (
    input  cpu_req, mem_w, addr_bus, Cpu_data2bus, slv_rdata, slv_ack,
    output Cpu_data4bus, cpu_ready, bus_err, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mio_addr_dec.sv
// mio_addr_dec: base/mask slot compare; on multiple hits the lowest slot index wins
module mio_addr_dec
  import mio_bus_pkg::*;
#(
  parameter int N_SLV  = 4,
  parameter int ADDR_W = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_MASK,
  localparam int IDX_W = idx_width(N_SLV)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx,
  output logic [N_SLV-1:0]  o_onehot
);
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    o_onehot = o_hit ? N_SLV'(1) << o_idx : '0;
  end
endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: handshaked CPU-to-slave bus controller with decode, ack wait and timeout
// Optional bus-error address log enabled by MIO_BUS_ERR_LOG_EN.
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int N_SLV  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_MASK,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MIO_BUS_ERR_LOG_EN
  input  logic              err_clr,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
`endif
  mio_bus_ctrl_if.slave     bus
);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam int IDX_W = idx_width(N_SLV);
  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [IDX_W-1:0]  r_idx, w_idx, w_dec_idx;
  logic [N_SLV-1:0]  r_sel, w_sel, w_dec_onehot;
  logic              w_hit, r_we, w_we, r_ready, w_ready, r_err, w_err, w_ack;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata, r_rdata, w_rdata, w_sel_rdata;
  mio_addr_dec #(
    .N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_dec (
    .i_addr(bus.addr_bus), .o_hit(w_hit), .o_idx(w_dec_idx), .o_onehot(w_dec_onehot)
  );
  // only the latched slot's ack and read data are visible; stray acks fall away here
  always_comb begin
    w_ack       = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++)
      if (r_idx == IDX_W'(i)) begin
        w_ack       = bus.slv_ack[i];
        w_sel_rdata = bus.slv_rdata[i*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_sel   = r_sel;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    w_err   = r_err;
    w_ready = 1'b0;
    case (r_state)
      IDLE: if (bus.cpu_req) begin
        if (w_hit) begin
          w_state = ACCESS;
          w_cnt   = '0;
          w_idx   = w_dec_idx;
          w_sel   = w_dec_onehot;
          w_we    = bus.mem_w;
          w_addr  = bus.addr_bus;
          w_wdata = bus.Cpu_data2bus;
        end else begin
          w_state = RESP;
          w_err   = 1'b1;
          w_rdata = '0;
          w_ready = 1'b1;
        end
      end
      ACCESS: if (w_ack) begin
        w_state = RESP;
        w_sel   = '0;
        w_we    = 1'b0;
        w_err   = 1'b0;
        w_rdata = r_we ? '0 : w_sel_rdata;
        w_ready = 1'b1;
      end else if (TIMEOUT != 0 && r_cnt == CNT_W'(TIMEOUT)) begin
        w_state = RESP;
        w_sel   = '0;
        w_we    = 1'b0;
        w_err   = 1'b1;
        w_rdata = '0;
        w_ready = 1'b1;
      end else
        w_cnt = r_cnt + 1'b1;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_sel   <= w_sel;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_err   <= w_err;
      r_ready <= w_ready;
    end
`ifdef MIO_BUS_ERR_LOG_EN
  logic              r_err_valid;
  logic [ADDR_W-1:0] r_err_addr;
  // an unmapped error is raised from IDLE before anything is latched, so log the live address
  always_ff @(posedge clk)
    if (rst) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_ready && w_err && (!r_err_valid || err_clr)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= r_state == IDLE ? bus.addr_bus : r_addr;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
`endif
  assign bus.Cpu_data4bus = r_rdata;
  assign bus.cpu_ready    = r_ready;
  assign bus.bus_err      = r_err;
  assign bus.slv_sel      = r_sel;
  assign bus.slv_we       = r_we;
  assign bus.slv_addr     = r_addr;
  assign bus.slv_wdata    = r_wdata;
endmodule
